// File: rtl/irq_ctl.sv
// rtl/irq_ctl.sv - interrupt controller: sync, edge/level latch, NMI-first arbitration, vector hold
module irq_ctl #(
  parameter int          CHANNELS  = 8,
  parameter logic [7:0]  EDGE_MASK = 8'hFF,
  parameter logic [7:0]  VEC_BASE  = 8'hE0,
  parameter logic [7:0]  NMI_VEC   = 8'hFA
) (
  input  logic                clk,
  input  logic                RST,
  input  logic [CHANNELS-1:0] irq_in,
  input  logic                NMI,
  input  logic                sync,
  input  logic                RDY,
  input  logic                I,
  input  logic                ack,
  output logic                int_req,
  output logic                int_nmi,
  output logic [7:0]          vec,
  input  logic                reg_we,
  input  logic [1:0]          reg_addr,
  input  logic [7:0]          reg_di,
  output logic [7:0]          reg_do
);

  localparam logic [7:0] CH_MASK    = 8'((9'd1 << CHANNELS) - 9'd1);
  localparam logic [7:0] EDGE_BITS  = EDGE_MASK & CH_MASK;
  localparam logic [7:0] LEVEL_BITS = ~EDGE_MASK & CH_MASK;

  typedef enum logic {IDLE, REQ} state_t;

  state_t     state, state_n;
  logic [7:0] irq_ext;
  logic [7:0] irq_s1, irq_s2, irq_s3;
  logic       nmi_s1, nmi_s2, nmi_s3;
  logic [7:0] irq_rise;
  logic       nmi_rise;
  logic [7:0] pending, pending_n;
  logic [7:0] enable;
  logic       nmi_pend;
  logic [7:0] eligible;
  logic       any_elig;
  logic [2:0] arb_idx;
  logic       take, done;
  logic       cap_nmi;
  logic [2:0] cap_idx;
  logic [7:0] ack_clr, w1c_clr;

  assign irq_ext = 8'(irq_in);

  // Stage 3 exists only to give the edge detector a delayed copy of stage 2.
  always_ff @(posedge clk) begin
    if (RST) begin
      irq_s1 <= 8'h00;
      irq_s2 <= 8'h00;
      irq_s3 <= 8'h00;
      nmi_s1 <= 1'b0;
      nmi_s2 <= 1'b0;
      nmi_s3 <= 1'b0;
    end else begin
      irq_s1 <= irq_ext & CH_MASK;
      irq_s2 <= irq_s1;
      irq_s3 <= irq_s2;
      nmi_s1 <= NMI;
      nmi_s2 <= nmi_s1;
      nmi_s3 <= nmi_s2;
    end
  end

  assign irq_rise = irq_s2 & ~irq_s3 & EDGE_BITS;
  assign nmi_rise = nmi_s2 & ~nmi_s3;

  assign eligible = pending & enable & ~{8{I}} & CH_MASK;

  always_comb begin
    arb_idx  = 3'd0;
    any_elig = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (eligible[k]) begin
        arb_idx  = 3'(k);
        any_elig = 1'b1;
      end
    end
  end

  assign take = (state == IDLE) && sync && RDY && (nmi_pend || any_elig);
  assign done = (state == REQ) && ack && RDY;

  always_ff @(posedge clk) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (take) state_n = REQ;
      REQ:     if (done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    int_req = (state == REQ);
  end

  // Set terms are OR'd after the clears so a same-cycle rise always survives.
  assign ack_clr = (done && !cap_nmi) ? (8'd1 << cap_idx) : 8'h00;
  assign w1c_clr = (reg_we && reg_addr == 2'd1) ? reg_di : 8'h00;
  assign pending_n = ((irq_rise | (pending & ~(ack_clr | w1c_clr))) & EDGE_BITS)
                   | (irq_s2 & LEVEL_BITS);

  always_ff @(posedge clk) begin
    if (RST) begin
      pending  <= 8'h00;
      nmi_pend <= 1'b0;
      enable   <= 8'h00;
    end else begin
      pending  <= pending_n;
      nmi_pend <= nmi_rise | (nmi_pend & ~(done & cap_nmi));
      if (reg_we && reg_addr == 2'd0) enable <= reg_di & CH_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      cap_nmi <= 1'b0;
      cap_idx <= 3'd0;
      vec     <= 8'h00;
    end else if (take) begin
      cap_nmi <= nmi_pend;
      cap_idx <= nmi_pend ? 3'd0 : arb_idx;
      vec     <= nmi_pend ? NMI_VEC : VEC_BASE + {4'b0000, arb_idx, 1'b0};
    end
  end

  assign int_nmi = cap_nmi;

  always_ff @(posedge clk) begin
    if (RST) begin
      reg_do <= 8'h00;
    end else begin
      case (reg_addr)
        2'd0:    reg_do <= enable;
        2'd1:    reg_do <= pending;
        2'd2:    reg_do <= {int_req, cap_nmi, nmi_pend, 2'b00, cap_idx};
        default: reg_do <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctl.sv
// tb/tb_irq_ctl.sv - directed bench for irq_ctl (channel 0 level, channels 1-7 edge)
module tb_irq_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic       nmi;
  logic       sync;
  logic       rdy;
  logic       i_flag;
  logic       ack;
  logic       int_req;
  logic       int_nmi;
  logic [7:0] vec;
  logic       reg_we;
  logic [1:0] reg_addr;
  logic [7:0] reg_di;
  logic [7:0] reg_do;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctl #(
    .CHANNELS (8),
    .EDGE_MASK(8'hFE),
    .VEC_BASE (8'hE0),
    .NMI_VEC  (8'hFA)
  ) dut (
    .clk     (clk),
    .RST     (rst),
    .irq_in  (irq_in),
    .NMI     (nmi),
    .sync    (sync),
    .RDY     (rdy),
    .I       (i_flag),
    .ack     (ack),
    .int_req (int_req),
    .int_nmi (int_nmi),
    .vec     (vec),
    .reg_we  (reg_we),
    .reg_addr(reg_addr),
    .reg_di  (reg_di),
    .reg_do  (reg_do)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    reg_addr = a;
    reg_di   = d;
    reg_we   = 1'b1;
    step();
    reg_we   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; irq_in = 8'h00; nmi = 1'b0; sync = 1'b0; rdy = 1'b1;
    i_flag = 1'b0; ack = 1'b0; reg_we = 1'b0; reg_addr = 2'd0; reg_di = 8'h00;
    step(); step();
    check("rst_int_req", {7'd0, int_req}, 8'h00);
    check("rst_int_nmi", {7'd0, int_nmi}, 8'h00);
    check("rst_vec", vec, 8'h00);
    check("rst_reg_do", reg_do, 8'h00);
    rst = 1'b0;

    // single edge channel 3
    wr(2'd0, 8'h08);
    irq_in = 8'h08;
    reg_addr = 2'd1;
    step(); step(); step();
    check("t1_pend_early", reg_do, 8'h00);
    step();
    check("t1_pend_lat", reg_do, 8'h08);
    check("t1_no_req", {7'd0, int_req}, 8'h00);
    sync = 1'b1; step(); sync = 1'b0;
    check("t1_int_req", {7'd0, int_req}, 8'h01);
    check("t1_vec", vec, 8'hE6);
    check("t1_int_nmi", {7'd0, int_nmi}, 8'h00);
    ack = 1'b1; step(); ack = 1'b0;
    check("t1_ack_req", {7'd0, int_req}, 8'h00);
    step();
    check("t1_ack_pend", reg_do, 8'h00);

    // channels 2 and 5 together, lowest wins; RDY low stalls ack
    irq_in = 8'h24;
    wr(2'd0, 8'h24);
    step(); step();
    sync = 1'b1; step(); sync = 1'b0;
    check("t2_vec_a", vec, 8'hE4);
    rdy = 1'b0; ack = 1'b1; step();
    check("t2_stall_req", {7'd0, int_req}, 8'h01);
    rdy = 1'b1; step(); ack = 1'b0;
    check("t2_ack_req", {7'd0, int_req}, 8'h00);
    reg_addr = 2'd1; step();
    check("t2_pend_after", reg_do, 8'h20);
    sync = 1'b1; step(); sync = 1'b0;
    check("t2_int_req_b", {7'd0, int_req}, 8'h01);
    check("t2_vec_b", vec, 8'hEA);
    ack = 1'b1; step(); ack = 1'b0;

    // I masks channel 0, NMI still taken
    i_flag = 1'b1;
    irq_in = 8'h25;
    wr(2'd0, 8'h01);
    step(); step();
    sync = 1'b1; step(); sync = 1'b0;
    check("t3_masked", {7'd0, int_req}, 8'h00);
    nmi = 1'b1;
    step(); step(); step();
    sync = 1'b1; step(); sync = 1'b0;
    check("t3_nmi_req", {7'd0, int_req}, 8'h01);
    check("t3_nmi_flag", {7'd0, int_nmi}, 8'h01);
    check("t3_nmi_vec", vec, 8'hFA);
    reg_addr = 2'd2; step();
    check("t3_status", reg_do, 8'hE0);
    ack = 1'b1; step(); ack = 1'b0;
    check("t3_ack_req", {7'd0, int_req}, 8'h00);
    step();
    check("t3_nmi_pend_clr", reg_do & 8'hA0, 8'h00);
    reg_addr = 2'd1; step();
    check("t3_ch0_pend", reg_do, 8'h01);
    nmi = 1'b0;

    // W1C and a new rise on the captured channel in the same cycle
    i_flag = 1'b0;
    irq_in = 8'h27;
    wr(2'd0, 8'h02);
    step(); step();
    sync = 1'b1; step(); sync = 1'b0;
    check("t4_req", {7'd0, int_req}, 8'h01);
    check("t4_vec", vec, 8'hE2);
    irq_in = 8'h25;
    step(); step(); step();
    irq_in = 8'h27;
    step(); step();
    wr(2'd1, 8'hFF);
    check("t4_vec_frozen", vec, 8'hE2);
    check("t4_req_held", {7'd0, int_req}, 8'h01);
    reg_addr = 2'd1; step();
    check("t4_set_wins", reg_do, 8'h03);
    ack = 1'b1; step(); ack = 1'b0;
    check("t4_ack_req", {7'd0, int_req}, 8'h00);
    step();
    check("t4_ack_pend", reg_do, 8'h01);

    // W1C clears edge bits only; level channel re-requests
    irq_in = 8'h67;
    step(); step(); step(); step();
    check("t5_pend_set", reg_do, 8'h41);
    wr(2'd1, 8'hFF);
    step();
    check("t5_w1c_level", reg_do, 8'h01);
    wr(2'd0, 8'h01);
    sync = 1'b1; step(); sync = 1'b0;
    check("t5_lvl_req", {7'd0, int_req}, 8'h01);
    check("t5_lvl_vec", vec, 8'hE0);
    ack = 1'b1; step(); ack = 1'b0;
    check("t5_lvl_ack", {7'd0, int_req}, 8'h00);
    sync = 1'b1; step(); sync = 1'b0;
    check("t5_lvl_again", {7'd0, int_req}, 8'h01);
    check("t5_lvl_vec2", vec, 8'hE0);

    // reset while a request is outstanding
    rst = 1'b1; irq_in = 8'h00; step(); rst = 1'b0;
    check("t6_int_req", {7'd0, int_req}, 8'h00);
    check("t6_vec", vec, 8'h00);
    check("t6_int_nmi", {7'd0, int_nmi}, 8'h00);
    check("t6_reg_do", reg_do, 8'h00);
    reg_addr = 2'd0; step();
    check("t6_enable", reg_do, 8'h00);
    reg_addr = 2'd1; step();
    check("t6_pending", reg_do, 8'h00);
    reg_addr = 2'd2; step();
    check("t6_status", reg_do, 8'h00);
    ack = 1'b1; step(); ack = 1'b0;
    check("t6_ack_idle", {7'd0, int_req}, 8'h00);
    wr(2'd3, 8'hFF);
    step();
    check("t6_reserved", reg_do, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
